// File: rtl/player_collider_if.sv
// Bus between the player controller and the collision-boundary generator.
// The controller is the master: it drives the position and map writes and reads back the bounds.
interface player_collider_if;
    logic [9:0]  player_X_Pos;
    logic [9:0]  player_Y_Pos;
    logic        map_we;
    logic [4:0]  map_row;
    logic [39:0] map_wdata;
    logic [9:0]  player_X_Min;
    logic [9:0]  player_X_Max;
    logic [9:0]  player_Y_Min;
    logic [9:0]  player_Y_Max;

    modport master (
        output player_X_Pos, player_Y_Pos, map_we, map_row, map_wdata,
        input  player_X_Min, player_X_Max, player_Y_Min, player_Y_Max
    );
    modport slave (
        input  player_X_Pos, player_Y_Pos, map_we, map_row, map_wdata,
        output player_X_Min, player_X_Max, player_Y_Min, player_Y_Max
    );
endinterface

// File: rtl/player_collider.sv
// Tile-map collision bounds for one player box; registered outputs with one cycle of latency.
// Optional macro COLLIDER_BORDER_EN: the outer tile ring always reads as solid.
module player_collider #(
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 48,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic              Clk,
    input logic              Reset,
    player_collider_if.slave bus
);
    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic [COLS-1:0] map_q [ROWS];
    logic [COLS-1:0] eff   [ROWS];

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_eff
`ifdef COLLIDER_BORDER_EN
        localparam logic [COLS-1:0] RING = (gr == 0 || gr == ROWS-1) ? '1 : {1'b1, {(COLS-2){1'b0}}, 1'b1};
        assign eff[gr] = map_q[gr] | RING;
`else
        assign eff[gr] = map_q[gr];
`endif
    end

    // Tile span, with both ends clamped so off-screen positions still scan the last column/row
    logic [10:0] x_end, y_end, c1_w, r1_w;
    logic [9:0]  c0_w, r0_w;
    logic [5:0]  c0, c1;
    logic [4:0]  r0, r1;

    assign x_end = {1'b0, bus.player_X_Pos} + 11'(PLAYER_W - 1);
    assign y_end = {1'b0, bus.player_Y_Pos} + 11'(PLAYER_H - 1);
    assign c0_w  = bus.player_X_Pos >> 4;
    assign r0_w  = bus.player_Y_Pos >> 4;
    assign c1_w  = x_end >> 4;
    assign r1_w  = y_end >> 4;
    assign c0    = (c0_w > 10'd39) ? 6'd39 : c0_w[5:0];
    assign c1    = (c1_w > 11'd39) ? 6'd39 : c1_w[5:0];
    assign r0    = (r0_w > 10'd29) ? 5'd29 : r0_w[4:0];
    assign r1    = (r1_w > 11'd29) ? 5'd29 : r1_w[4:0];

    logic [COLS-1:0] row_or, col_mask;
    logic [ROWS-1:0] row_blk;
    logic            cl_hit, cr_hit, ru_hit, rd_hit;
    logic [5:0]      cl, cr;
    logic [4:0]      ru, rd;
    logic [9:0]      x_min_d, x_max_d, y_min_d, y_max_d;

    always_comb begin
        row_or   = '0;
        col_mask = '0;
        row_blk  = '0;
        cl_hit = 1'b0; cl = '0;
        cr_hit = 1'b0; cr = '0;
        ru_hit = 1'b0; ru = '0;
        rd_hit = 1'b0; rd = '0;
        for (int c = 0; c < COLS; c++)
            col_mask[c] = (6'(c) >= c0) && (6'(c) <= c1);
        for (int r = 0; r < ROWS; r++) begin
            if (5'(r) >= r0 && 5'(r) <= r1) row_or = row_or | eff[r];
            row_blk[r] = |(eff[r] & col_mask);
        end
        // Ascending scan keeps the last hit below c0 (nearest left wall)
        for (int c = 0; c < COLS; c++)
            if (row_or[c] && 6'(c) < c0) begin cl_hit = 1'b1; cl = 6'(c); end
        for (int c = COLS-1; c >= 0; c--)
            if (row_or[c] && 6'(c) > c1) begin cr_hit = 1'b1; cr = 6'(c); end
        for (int r = 0; r < ROWS; r++)
            if (row_blk[r] && 5'(r) < r0) begin ru_hit = 1'b1; ru = 5'(r); end
        for (int r = ROWS-1; r >= 0; r--)
            if (row_blk[r] && 5'(r) > r1) begin rd_hit = 1'b1; rd = 5'(r); end
        x_min_d = cl_hit ? {cl + 6'd1, 4'b0}       : 10'd0;
        x_max_d = cr_hit ? {cr, 4'b0}              : 10'(SCREEN_W);
        y_min_d = ru_hit ? {1'b0, ru + 5'd1, 4'b0} : 10'd0;
        y_max_d = rd_hit ? {1'b0, rd, 4'b0}        : 10'(SCREEN_H);
    end

    logic [9:0] x_min_q, x_max_q, y_min_q, y_max_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < ROWS; r++) map_q[r] <= '0;
            x_min_q <= '0;
            x_max_q <= 10'(SCREEN_W);
            y_min_q <= '0;
            y_max_q <= 10'(SCREEN_H);
        end else begin
            if (bus.map_we && bus.map_row < 5'd30) map_q[bus.map_row] <= bus.map_wdata;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
        end
    end

    assign bus.player_X_Min = x_min_q;
    assign bus.player_X_Max = x_max_q;
    assign bus.player_Y_Min = y_min_q;
    assign bus.player_Y_Max = y_max_q;
endmodule

// File: tb/tb_player_collider.sv
// Self-checking bench for player_collider: directed scenarios plus random map/position traffic
// checked against a tile-level reference model.
module tb_player_collider;
    localparam int PW = 32;
    localparam int PH = 48;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    player_collider_if bus();

    player_collider #(.PLAYER_W(PW), .PLAYER_H(PH), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [39:0] mdl [30];
    logic [39:0] exp_b;
    wire  [39:0] got_b = {bus.player_X_Min, bus.player_X_Max, bus.player_Y_Min, bus.player_Y_Max};

    function automatic bit solid(input int r, input int c);
`ifdef COLLIDER_BORDER_EN
        if (r == 0 || r == 29 || c == 0 || c == 39) return 1'b1;
`endif
        return mdl[r][c];
    endfunction

    // Walk outward from the player's span, one tile at a time, until something solid is seen
    function automatic logic [39:0] model(input int x, input int y);
        int c0, c1, r0, r1, xmin, xmax, ymin, ymax;
        bit hit;
        c0 = x / 16;           if (c0 > 39) c0 = 39;
        c1 = (x + PW - 1) / 16; if (c1 > 39) c1 = 39;
        r0 = y / 16;           if (r0 > 29) r0 = 29;
        r1 = (y + PH - 1) / 16; if (r1 > 29) r1 = 29;
        xmin = 0; xmax = 640; ymin = 0; ymax = 480;
        for (int c = c0 - 1; c >= 0; c--) begin
            hit = 0;
            for (int r = r0; r <= r1; r++) if (solid(r, c)) hit = 1;
            if (hit) begin xmin = 16 * (c + 1); break; end
        end
        for (int c = c1 + 1; c < 40; c++) begin
            hit = 0;
            for (int r = r0; r <= r1; r++) if (solid(r, c)) hit = 1;
            if (hit) begin xmax = 16 * c; break; end
        end
        for (int r = r0 - 1; r >= 0; r--) begin
            hit = 0;
            for (int c = c0; c <= c1; c++) if (solid(r, c)) hit = 1;
            if (hit) begin ymin = 16 * (r + 1); break; end
        end
        for (int r = r1 + 1; r < 30; r++) begin
            hit = 0;
            for (int c = c0; c <= c1; c++) if (solid(r, c)) hit = 1;
            if (hit) begin ymax = 16 * r; break; end
        end
        return {10'(xmin), 10'(xmax), 10'(ymin), 10'(ymax)};
    endfunction

    // One clock: drive at negedge, predict from the pre-edge map, apply the write, settle past the edge
    task automatic step(input bit rst, input int x, input int y, input bit we, input int row, input logic [39:0] d);
        @(negedge Clk);
        Reset = rst;
        bus.player_X_Pos = 10'(x);
        bus.player_Y_Pos = 10'(y);
        bus.map_we = we;
        bus.map_row = 5'(row);
        bus.map_wdata = d;
        exp_b = rst ? {10'd0, 10'd640, 10'd0, 10'd480} : model(x, y);
        @(posedge Clk);
        if (rst) for (int r = 0; r < 30; r++) mdl[r] = '0;
        else if (we && row < 30) mdl[row] = d;
        #1;
    endtask

    task automatic test_reset;
        step(1, 100, 200, 1, 4, '1);
        checks++;
        if (got_b !== 40'({10'd0, 10'd640, 10'd0, 10'd480})) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", got_b, {10'd0, 10'd640, 10'd0, 10'd480});
        end
        step(0, 100, 200, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL reset_empty got=%h exp=%h", got_b, exp_b); end
    endtask

    task automatic test_floor;
        step(1, 0, 0, 0, 0, '0);
        step(0, 32, 300, 1, 27, '1);
        step(0, 32, 300, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL floor got=%h exp=%h", got_b, exp_b); end
`ifndef COLLIDER_BORDER_EN
        checks++;
        if (got_b !== {10'd0, 10'd640, 10'd0, 10'd432}) begin
            errors++; $display("FAIL floor_const got=%h exp=%h", got_b, {10'd0, 10'd640, 10'd0, 10'd432});
        end
`endif
    endtask

    task automatic test_wall;
        step(1, 0, 0, 0, 0, '0);
        for (int r = 0; r < 30; r++) step(0, 120, 100, 1, r, 40'd1 << 5);
        step(0, 120, 100, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL wall_left got=%h exp=%h", got_b, exp_b); end
        checks++;
        if (bus.player_X_Min !== 10'd96) begin errors++; $display("FAIL wall_left_xmin got=%0d exp=96", bus.player_X_Min); end
        step(0, 20, 100, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL wall_right got=%h exp=%h", got_b, exp_b); end
        checks++;
        if (bus.player_X_Max !== 10'd80) begin errors++; $display("FAIL wall_right_xmax got=%0d exp=80", bus.player_X_Max); end
    endtask

    task automatic test_ceiling;
        step(1, 0, 0, 0, 0, '0);
        step(0, 128, 100, 1, 2, 40'd1 << 8);
        step(0, 128, 100, 0, 0, '0);
        checks++;
        if (bus.player_Y_Min !== 10'd48) begin errors++; $display("FAIL ceiling_ymin got=%0d exp=48", bus.player_Y_Min); end
        step(0, 300, 100, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL ceiling_outside got=%h exp=%h", got_b, exp_b); end
`ifndef COLLIDER_BORDER_EN
        checks++;
        if (bus.player_Y_Min !== 10'd0) begin errors++; $display("FAIL ceiling_outside_ymin got=%0d exp=0", bus.player_Y_Min); end
`endif
    endtask

    task automatic test_overlap;
        step(1, 0, 0, 0, 0, '0);
        for (int r = 0; r < 30; r++) step(0, 32, 200, 1, r, 40'd1 << 2);
        step(0, 32, 200, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL overlap got=%h exp=%h", got_b, exp_b); end
`ifndef COLLIDER_BORDER_EN
        checks++;
        if (bus.player_X_Min !== 10'd0) begin errors++; $display("FAIL overlap_xmin got=%0d exp=0", bus.player_X_Min); end
`endif
    endtask

    task automatic test_offscreen;
        step(1, 0, 0, 0, 0, '0);
        step(0, 1000, 1000, 1, 10, 40'h00_0000_0F00);
        step(0, 1000, 1000, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            step(0, 600 + 100 * i, 440 + 100 * i, 0, 0, '0);
            checks++;
            if (got_b !== exp_b) begin errors++; $display("FAIL offscreen i=%0d got=%h exp=%h", i, got_b, exp_b); end
        end
    endtask

    task automatic test_reset_with_write;
        step(1, 0, 0, 0, 0, '0);
        for (int r = 5; r < 25; r += 4) step(0, 200, 200, 1, r, 40'hFF_FFFF_FFFF);
        step(1, 200, 200, 1, 20, '1);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL reset_we_state got=%h exp=%h", got_b, exp_b); end
        step(0, 200, 200, 0, 0, '0);
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL reset_we_cleared got=%h exp=%h", got_b, exp_b); end
`ifndef COLLIDER_BORDER_EN
        checks++;
        if (got_b !== {10'd0, 10'd640, 10'd0, 10'd480}) begin
            errors++; $display("FAIL reset_we_const got=%h exp=%h", got_b, {10'd0, 10'd640, 10'd0, 10'd480});
        end
`endif
    endtask

    task automatic test_random;
        logic [39:0] d;
        int x, y;
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
            y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
            step($urandom_range(0, 79) == 0, x, y, $urandom_range(0, 2) == 0, $urandom_range(0, 31), d);
            checks++;
            if (got_b !== exp_b) begin errors++; $display("FAIL random i=%0d x=%0d y=%0d got=%h exp=%h", i, x, y, got_b, exp_b); end
            checks++;
            if (bus.player_X_Min > bus.player_X_Max || bus.player_Y_Min > bus.player_Y_Max) begin
                errors++; $display("FAIL invariant i=%0d got=%h", i, got_b);
            end
        end
    endtask

    initial begin
        bus.player_X_Pos = '0;
        bus.player_Y_Pos = '0;
        bus.map_we = 1'b0;
        bus.map_row = '0;
        bus.map_wdata = '0;
        for (int r = 0; r < 30; r++) mdl[r] = '0;
        test_reset;
        test_floor;
        test_wall;
        test_ceiling;
        test_overlap;
        test_offscreen;
        test_reset_with_write;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
